// File: rtl/apb_mem_slave.sv
// -----------------------------------------------------------------------------
// apb_mem_slave
//
// APB4 completer backed by an internal register-array memory. Used behind the
// APB bridge as a scratchpad or mailbox. Every transfer takes
// 2 + WAIT_STATES cycles (setup, WAIT_STATES waits, one ready cycle). Writes
// honour byte strobes. Accesses whose word index falls beyond DEPTH complete
// with pslverr=1 and leave the memory alone. All outputs are registered.
//
// Parameters
//   ADDR_WIDTH  : width of paddr (byte address)
//   DATA_WIDTH  : data bus width, one of 8/16/32/64
//   DEPTH       : number of DATA_WIDTH words held
//   WAIT_STATES : access-phase cycles with pready=0 before completion, 0..15
//
// Ports
//   pclk     in   clock, all state on the rising edge
//   presetn  in   asynchronous active-low reset
//   psel     in   completer select
//   penable  in   access-phase indicator
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address
//   pwdata   in   write data
//   pstrb    in   byte-lane write strobes
//   prdata   out  read data, valid while pready=1 on a read, else 0
//   pready   out  transfer completion, high for exactly one cycle
//   pslverr  out  error response, valid while pready=1
// -----------------------------------------------------------------------------
module apb_mem_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int OFFS_W    = $clog2(NUM_LANES);
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so DEPTH == 2**ADDR_WIDTH (full 8-bit map) still compares
    // correctly instead of truncating to zero.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t                 state_q,   state_d;
    logic [3:0]             cnt_q,     cnt_d;
    logic [IDX_W-1:0]       idx_q,     idx_d;
    logic                   wr_q,      wr_d;
    logic                   err_q,     err_d;
    logic                   pready_d;
    logic                   pslverr_d;
    logic [DATA_WIDTH-1:0]  prdata_d;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic                   mem_we;

    // -------------------------------------------------------------------------
    // Address decode (meaningful in the setup cycle only)
    // -------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]  word_addr;
    logic [IDX_W-1:0]       dec_idx;
    logic                   dec_err;

    assign word_addr = paddr >> OFFS_W;
    assign dec_idx   = word_addr[IDX_W-1:0];
    assign dec_err   = ({1'b0, word_addr} >= DEPTH_LIMIT);

    // The ready-cycle outputs are loaded either straight from the setup-cycle
    // decode (zero wait states) or from the values latched at setup (after
    // waiting). Selecting here keeps a single load path in the FSM.
    logic [IDX_W-1:0]       ld_idx;
    logic                   ld_wr;
    logic                   ld_err;
    logic [DATA_WIDTH-1:0]  ld_rdata;

    assign ld_idx   = (state_q == ST_IDLE) ? dec_idx : idx_q;
    assign ld_wr    = (state_q == ST_IDLE) ? pwrite  : wr_q;
    assign ld_err   = (state_q == ST_IDLE) ? dec_err : err_q;
    assign ld_rdata = (ld_wr || ld_err) ? '0 : mem[ld_idx];

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned, which is what would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        err_d     = err_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        mem_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    idx_d = dec_idx;
                    wr_d  = pwrite;
                    err_d = dec_err;
                    cnt_d = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d   = ST_READY;
                        pready_d  = 1'b1;
                        pslverr_d = ld_err;
                        prdata_d  = ld_rdata;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!psel) begin
                    // Requester abandoned the transfer: nothing completes.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d   = ST_READY;
                    pready_d  = 1'b1;
                    pslverr_d = ld_err;
                    prdata_d  = ld_rdata;
                end
            end

            ST_READY: begin
                // Completion edge: pwdata/pstrb are sampled here.
                mem_we  = psel && penable && wr_q && !err_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            pready  <= pready_d;
            pslverr <= pslverr_d;
            prdata  <= prdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Memory array
    // -------------------------------------------------------------------------
    // NOTE: the array is deliberately left out of reset; it is plain storage
    // whose contents are undefined until written. An in-flight write is still
    // dropped on reset because mem_we derives from the reset FSM state.
    always_ff @(posedge pclk) begin
        if (mem_we) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (pstrb[i]) begin
                    mem[idx_q][i*8 +: 8] <= pwdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_mem_slave
//
// Two instances share one APB bus (separate psel each): dut_a with two wait
// states, dut_b with none. Expected results come from a byte-addressed
// reference memory per instance with per-byte "written" flags.
// -----------------------------------------------------------------------------
module tb_apb_mem_slave;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NB = DW / 8;
    localparam int DEPTH = 64;
    localparam int MAX_CYC = 40;

    logic          pclk;
    logic          presetn;
    logic          psel_a, psel_b;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [NB-1:0] pstrb;
    logic [DW-1:0] prdata_a, prdata_b;
    logic          pready_a, pready_b;
    logic          pslverr_a, pslverr_b;

    apb_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(2)) dut_a (
        .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
    );

    apb_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(0)) dut_b (
        .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ------------------------------------------------------- reference model
    // Byte-addressed image of each instance's memory; a byte is compared only
    // once it has been written.
    int   ws_of [2] = '{2, 0};
    logic [7:0] mb  [2][DEPTH*NB];
    bit         mbv [2][DEPTH*NB];

    function automatic logic rdy(input int t);
        return (t == 1) ? pready_b : pready_a;
    endfunction

    function automatic logic [DW-1:0] rdat(input int t);
        return (t == 1) ? prdata_b : prdata_a;
    endfunction

    function automatic logic rerr(input int t);
        return (t == 1) ? pslverr_b : pslverr_a;
    endfunction

    // One complete APB transfer starting in the current cycle (caller is #1
    // after an edge). Leaves the bus idle #1 after the completion edge so a
    // following call starts its setup with no idle cycle in between.
    task automatic xfer(input string tag, input int t, input bit wr,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [NB-1:0] st, output logic [DW-1:0] rd);
        int  cyc;
        int  word;
        bit  exp_err;
        logic [DW-1:0] exp_d, mask;
        logic got_err;

        word    = int'(addr) / NB;
        exp_err = (word >= DEPTH);

        psel_a  = (t == 0);
        psel_b  = (t == 1);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        pstrb   = st;
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc = 2;
        while (!rdy(t) && cyc < MAX_CYC) begin
            @(posedge pclk); #1;
            cyc++;
        end
        check({tag, "_cycles"}, 64'(cyc), 64'(2 + ws_of[t]));
        rd      = rdat(t);
        got_err = rerr(t);
        check({tag, "_pslverr"}, 64'(got_err), 64'(exp_err));

        if (wr || exp_err) begin
            check({tag, "_prdata_zero"}, 64'(rd), 64'd0);
        end else begin
            exp_d = '0;
            mask  = '0;
            for (int i = 0; i < NB; i++) begin
                if (mbv[t][word*NB + i]) begin
                    exp_d[i*8 +: 8] = mb[t][word*NB + i];
                    mask[i*8 +: 8]  = 8'hFF;
                end
            end
            if (mask != '0) check({tag, "_prdata"}, 64'(rd & mask), 64'(exp_d));
        end

        @(posedge pclk); #1;
        check({tag, "_pready_drop"}, 64'(rdy(t)), 64'd0);
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;

        if (wr && !exp_err) begin
            for (int i = 0; i < NB; i++) begin
                if (st[i]) begin
                    mb[t][word*NB + i]  = wd[i*8 +: 8];
                    mbv[t][word*NB + i] = 1'b1;
                end
            end
        end
    endtask

    // Drive a setup phase on dut_a only, without completing it.
    task automatic setup_a(input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        psel_a  = 1'b1;
        psel_b  = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = addr;
        pwdata  = wd;
        pstrb   = '1;
    endtask

    // ---------------------------------------------------------------- stimulus
    logic [DW-1:0] rd;
    int            seen;

    initial begin
        presetn = 1'b0;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        for (int t = 0; t < 2; t++)
            for (int b = 0; b < DEPTH*NB; b++) mbv[t][b] = 1'b0;

        repeat (3) @(posedge pclk);
        #1;
        check("rst_pready_a",  64'(pready_a),  64'd0);
        check("rst_pslverr_a", 64'(pslverr_a), 64'd0);
        check("rst_prdata_a",  64'(prdata_a),  64'd0);
        check("rst_pready_b",  64'(pready_b),  64'd0);
        check("rst_prdata_b",  64'(prdata_b),  64'd0);
        presetn = 1'b1;
        @(posedge pclk); #1;

        // Reset during WAIT of a write to 0x010.
        setup_a(12'h010, 32'hDEADBEEF);
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        presetn = 1'b0;
        #1;
        check("rstwait_pready",  64'(pready_a),  64'd0);
        check("rstwait_pslverr", 64'(pslverr_a), 64'd0);
        check("rstwait_prdata",  64'(prdata_a),  64'd0);
        psel_a  = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        xfer("rstwait_rd", 0, 1'b0, 12'h010, '0, '0, rd);
        check("rstwait_not_written", 64'(rd == 32'hDEADBEEF), 64'd0);

        // Reset while pready is high: completion write must be dropped.
        setup_a(12'h014, 32'hCAFEF00D);
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        check("rstrdy_pready_up", 64'(pready_a), 64'd1);
        presetn = 1'b0;
        #1;
        check("rstrdy_pready_async", 64'(pready_a), 64'd0);
        @(posedge pclk); #1;
        psel_a  = 1'b0;
        penable = 1'b0;
        presetn = 1'b1;
        @(posedge pclk); #1;
        xfer("rstrdy_rd", 0, 1'b0, 12'h014, '0, '0, rd);
        check("rstrdy_not_written", 64'(rd == 32'hCAFEF00D), 64'd0);

        // Basic write/read with two wait states.
        xfer("wr004", 0, 1'b1, 12'h004, 32'hA5A51234, 4'hF, rd);
        xfer("rd004", 0, 1'b0, 12'h004, '0, '0, rd);
        check("rd004_value", 64'(rd), 64'hA5A51234);

        // Byte strobes.
        xfer("wr008_all", 0, 1'b1, 12'h008, 32'hFFFFFFFF, 4'hF, rd);
        xfer("wr008_strb", 0, 1'b1, 12'h008, 32'h11223344, 4'b0101, rd);
        xfer("rd008", 0, 1'b0, 12'h008, '0, '0, rd);
        check("rd008_value", 64'(rd), 64'hFF22FF44);

        // Out-of-range accesses.
        xfer("wr000", 0, 1'b1, 12'h000, 32'h13579BDF, 4'hF, rd);
        xfer("wr100_oor", 0, 1'b1, 12'h100, 32'h00000055, 4'hF, rd);
        xfer("rd100_oor", 0, 1'b0, 12'h100, '0, '0, rd);
        check("rd100_value", 64'(rd), 64'd0);
        xfer("rd000", 0, 1'b0, 12'h000, '0, '0, rd);
        check("rd000_value", 64'(rd), 64'h13579BDF);

        // Back-to-back, zero wait states.
        xfer("b2b_wr0", 1, 1'b1, 12'h000, 32'h1, 4'hF, rd);
        xfer("b2b_wr1", 1, 1'b1, 12'h004, 32'h2, 4'hF, rd);
        xfer("b2b_wr2", 1, 1'b1, 12'h008, 32'h3, 4'hF, rd);
        xfer("b2b_rd0", 1, 1'b0, 12'h000, '0, '0, rd);
        check("b2b_rd0_value", 64'(rd), 64'h1);
        xfer("b2b_rd1", 1, 1'b0, 12'h004, '0, '0, rd);
        check("b2b_rd1_value", 64'(rd), 64'h2);
        xfer("b2b_rd2", 1, 1'b0, 12'h008, '0, '0, rd);
        check("b2b_rd2_value", 64'(rd), 64'h3);

        // Aborted transfer: psel dropped during WAIT.
        xfer("abort_pre", 0, 1'b1, 12'h00C, 32'h12345678, 4'hF, rd);
        setup_a(12'h00C, 32'h00000077);
        @(posedge pclk); #1;
        psel_a  = 1'b0;
        penable = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge pclk); #1;
            if (pready_a) seen++;
        end
        check("abort_no_pready", 64'(seen), 64'd0);
        xfer("abort_rd", 0, 1'b0, 12'h00C, '0, '0, rd);
        check("abort_rd_value", 64'(rd), 64'h12345678);

        // Randomised traffic on both instances, including out-of-range and
        // unaligned addresses; results checked inside xfer().
        for (int n = 0; n < 120; n++) begin
            int t;
            bit wr;
            logic [AW-1:0] a;
            t  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, 12'h13F));
            xfer($sformatf("rnd%0d", n), t, wr, a, DW'($urandom), NB'($urandom), rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parameterised APB4 completer backed by an internal register-array memory, generalising the team's 8-bit single-wait APB slave. Adds configurable data width, depth and wait states, byte strobes (`pstrb`), and error response (`pslverr`) for out-of-range accesses. Sits behind the APB bridge as a scratchpad or mailbox peripheral; all outputs are registered.

## Interface
- `ADDR_WIDTH`, 12: width of `paddr` (byte address).
- `DATA_WIDTH`, 32: data bus width; legal values 8, 16, 32, 64.
- `DEPTH`, 64: number of `DATA_WIDTH` words; `DEPTH*DATA_WIDTH/8 <= 2**ADDR_WIDTH`.
- `WAIT_STATES`, 0: access-phase cycles with `pready=0` before completion; legal 0..15.
- `pclk` in 1: the single clock; all state on rising edge.
- `presetn` in 1: reset, asynchronous and active-low.
- `psel` in 1: completer select.
- `penable` in 1: access-phase indicator.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in `ADDR_WIDTH`: byte address.
- `pwdata` in `DATA_WIDTH`: write data.
- `pstrb` in `DATA_WIDTH/8`: byte-lane write strobes.
- `prdata` out `DATA_WIDTH`: read data, valid only while `pready=1` on a read.
- `pready` out 1: transfer completion.
- `pslverr` out 1: error response, valid only while `pready=1`.

## Operation
- Word index = `paddr >> log2(DATA_WIDTH/8)`; low byte-offset bits ignored (no misalignment error).
- Out-of-range: index >= `DEPTH` -> `pslverr=1` at completion, no memory update, `prdata=0`.
- Write: at completion edge (`psel && penable && pready`), each byte lane `i` with `pstrb[i]=1` is written; lanes with `pstrb[i]=0` keep old value. `pstrb=0` is a legal no-op write, no error.
- Read: `prdata` loaded from memory at the edge that raises `pready`; 0 on writes and errors.
- FSM states:
  - IDLE: outputs 0. Edge with `psel && !penable`: load wait counter with `WAIT_STATES`; if 0 -> READY (load `pready=1`, `prdata`, `pslverr`), else -> WAIT.
  - WAIT: counter decrements each edge; at edge where counter==1 -> READY with same loads. If `psel==0` seen in WAIT -> IDLE, no write, outputs stay 0.
  - READY: `pready=1` for exactly one cycle; next edge performs write (if any, and no error), clears `pready`, `pslverr`, `prdata` to 0, -> IDLE.
- Memory contents are not reset and are undefined until written.
- Single-port: one access at a time; no read/write concurrency.

## Timing
- Reset (async assert, any state): `pready=0`, `pslverr=0`, `prdata=0`, FSM=IDLE, counter=0; memory untouched. In-flight write is dropped.
- Transfer length = 2 + `WAIT_STATES` cycles (setup, `WAIT_STATES` waits, 1 ready cycle).
- Back-to-back: the setup of the next transfer may occur in the cycle right after READY; no idle cycle required; throughput one transfer per 2+`WAIT_STATES` cycles.
- Write data visible to a read whose setup cycle follows the write's READY cycle.
- `pready` never asserts without a preceding setup cycle; never asserts for two consecutive cycles.
- Inputs sampled only in setup cycle (address/direction decode) and READY cycle (`pwdata`, `pstrb`); APB stability rules require them held meanwhile.

## Test plan
- Reset mid-transfer: assert `presetn=0` during WAIT of write 0xDEADBEEF to 0x010 -> outputs 0 immediately; subsequent read of 0x010 does not return 0xDEADBEEF.
- Write/read, `WAIT_STATES=2`: write 0xA5A5_1234 to 0x004, read 0x004 -> `pready` high exactly on 4th cycle of each transfer, `prdata=0xA5A51234`, `pslverr=0`.
- Strobes: write 0xFFFFFFFF to 0x008, then 0x11223344 with `pstrb=4'b0101` -> read returns 0xFF22FF44.
- Out-of-range: write 0x55 to 0x100 (index 64), read 0x100 -> both complete with `pslverr=1`, `prdata=0`; read of 0x000 unchanged.
- Back-to-back, `WAIT_STATES=0`: write 0x1,0x2,0x3 to 0x00,0x04,0x08 consecutively then read all -> each transfer 2 cycles, data 1,2,3.
- Aborted setup: `psel` dropped during WAIT of write 0x77 to 0x00C -> no `pready`, memory at 0x00C unchanged on readback.
